// File: rtl/axi_fifo_sync.sv
// Synchronous FIFO with arbitrary depth, FWFT or registered output, level and threshold flags.
// Define AXI_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module axi_fifo_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = 1
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       write_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       read_en,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       valid,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [LW-1:0]         level_q;
   logic                  rd_ok;
   logic                  wr_ok;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   assign empty        = (level_q == '0);
   assign full         = (level_q == LW'(DEPTH));
   assign almost_full  = (level_q >= LW'(AF_THRESH));
   assign almost_empty = (level_q <= LW'(AE_THRESH));
   assign level        = level_q;

   // A full FIFO still takes a write when the same edge pops the head.
   assign rd_ok = read_en & ~empty;
   assign wr_ok = write_en & (~full | rd_ok);

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (wr_ok & ~rd_ok) begin
            level_q <= level_q + LW'(1);
         end else if (rd_ok & ~wr_ok) begin
            level_q <= level_q - LW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok & ~clr) begin
         mem[wr_ptr] <= data_in;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem[rd_ptr];
         assign valid    = ~empty;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] data_p1;
         logic                  vld_p1;

         // Output stage: one-cycle read latency, data held between reads.
         always_ff @(posedge clk) begin
            if (clr) begin
               data_p1 <= '0;
               vld_p1  <= 1'b0;
            end else begin
               vld_p1 <= rd_ok;
               if (rd_ok) begin
                  data_p1 <= mem[rd_ptr];
               end
            end
         end

         assign data_out = data_p1;
         assign valid    = vld_p1;
      end
   endgenerate

`ifdef AXI_FIFO_ERR_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (write_en & full & ~rd_ok) begin
            overflow_q <= 1'b1;
         end
         if (read_en & empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_axi_fifo_sync.sv
// Scoreboard bench: DEPTH=4 FWFT instance and DEPTH=3 registered-output instance.
module tb_axi_fifo_sync;

`ifdef AXI_FIFO_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr;
   logic       mon_en = 1'b0;

   logic       a_we, a_re, a_valid, a_empty, a_full, a_af, a_ae, a_ovf, a_unf;
   logic [7:0] a_din, a_dout;
   logic [2:0] a_level;

   logic       b_we, b_re, b_valid, b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
   logic [7:0] b_din, b_dout;
   logic [1:0] b_level;

   logic [7:0] a_q[$];
   logic [7:0] b_q[$];
   logic       b_re_prev = 1'b0;

   int checks = 0;
   int errors = 0;

   axi_fifo_sync #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_a (
      .clk(clk), .clr(clr), .write_en(a_we), .data_in(a_din), .read_en(a_re),
      .data_out(a_dout), .valid(a_valid), .empty(a_empty), .full(a_full),
      .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
      .overflow(a_ovf), .underflow(a_unf)
   );

   axi_fifo_sync #(.DATA_WIDTH(8), .DEPTH(3), .AF_THRESH(2), .AE_THRESH(1), .FWFT(0)) u_b (
      .clk(clk), .clr(clr), .write_en(b_we), .data_in(b_din), .read_en(b_re),
      .data_out(b_dout), .valid(b_valid), .empty(b_empty), .full(b_full),
      .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
      .overflow(b_ovf), .underflow(b_unf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor A: a pop is accepted when read_en meets valid; the head must match the scoreboard.
   always @(negedge clk) begin
      logic [7:0] e;
      if (mon_en && a_re && a_valid) begin
         if (a_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_pop: unexpected pop of 0x%0h, none expected", a_dout);
         end else begin
            e = a_q.pop_front();
            chk("a_pop_data", 32'(a_dout), 32'(e));
         end
      end
   end

   // Monitor B: valid must follow read_en by one cycle; each valid beat pops the scoreboard.
   always @(negedge clk) begin
      logic [7:0] e;
      if (mon_en) begin
         chk("b_valid_latency", 32'(b_valid), 32'(b_re_prev));
         if (b_valid) begin
            if (b_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_read: unexpected data 0x%0h, none expected", b_dout);
            end else begin
               e = b_q.pop_front();
               chk("b_read_data", 32'(b_dout), 32'(e));
            end
         end
         b_re_prev <= b_re;
      end
   end

   task automatic a_drive(input logic we, input logic [7:0] d, input logic re);
      a_we = we; a_din = d; a_re = re;
      @(posedge clk); #1;
      a_we = 1'b0; a_din = 8'h00; a_re = 1'b0;
   endtask

   task automatic a_pop(input logic [7:0] exp);
      a_q.push_back(exp);
      a_drive(1'b0, 8'h00, 1'b1);
   endtask

   task automatic b_drive(input logic we, input logic [7:0] d, input logic re);
      b_we = we; b_din = d; b_re = re;
      @(posedge clk); #1;
      b_we = 1'b0; b_din = 8'h00; b_re = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      clr = 1'b1;
      a_we = 1'b0; a_re = 1'b0; a_din = 8'h00;
      b_we = 1'b0; b_re = 1'b0; b_din = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      mon_en = 1'b1;

      chk("a_rst_level", 32'(a_level), 32'd0);
      chk("a_rst_empty", 32'(a_empty), 32'd1);
      chk("a_rst_valid", 32'(a_valid), 32'd0);
      chk("a_rst_dout", 32'(a_dout), 32'h0);
      chk("a_rst_full", 32'(a_full), 32'd0);
      chk("a_rst_ae", 32'(a_ae), 32'd1);
      chk("a_rst_ovf", 32'(a_ovf), 32'd0);
      chk("a_rst_unf", 32'(a_unf), 32'd0);
      chk("b_rst_dout", 32'(b_dout), 32'h0);
      chk("b_rst_valid", 32'(b_valid), 32'd0);

      // Fill A0..A3 and drain in order.
      a_drive(1'b1, 8'hA0, 1'b0);
      chk("a_fwft_level1", 32'(a_level), 32'd1);
      chk("a_fwft_dout1", 32'(a_dout), 32'hA0);
      chk("a_fwft_valid1", 32'(a_valid), 32'd1);
      a_drive(1'b1, 8'hA1, 1'b0);
      chk("a_ae_level2", 32'(a_ae), 32'd0);
      a_drive(1'b1, 8'hA2, 1'b0);
      chk("a_af_level3", 32'(a_af), 32'd1);
      chk("a_full_level3", 32'(a_full), 32'd0);
      a_drive(1'b1, 8'hA3, 1'b0);
      chk("a_full", 32'(a_full), 32'd1);
      chk("a_level4", 32'(a_level), 32'd4);
      chk("a_af4", 32'(a_af), 32'd1);
      chk("a_dout_head", 32'(a_dout), 32'hA0);
      a_pop(8'hA0);
      chk("a_level_after_pop", 32'(a_level), 32'd3);
      a_pop(8'hA1);
      a_pop(8'hA2);
      a_pop(8'hA3);
      chk("a_drained_empty", 32'(a_empty), 32'd1);
      chk("a_drained_dout", 32'(a_dout), 32'h0);
      chk("a_drained_valid", 32'(a_valid), 32'd0);

      // Simultaneous write and read on a full FIFO.
      a_drive(1'b1, 8'h10, 1'b0);
      a_drive(1'b1, 8'h11, 1'b0);
      a_drive(1'b1, 8'h12, 1'b0);
      a_drive(1'b1, 8'h13, 1'b0);
      a_q.push_back(8'h10);
      a_drive(1'b1, 8'h55, 1'b1);
      chk("a_fullrw_level", 32'(a_level), 32'd4);
      chk("a_fullrw_full", 32'(a_full), 32'd1);
      chk("a_fullrw_head", 32'(a_dout), 32'h11);
      chk("a_fullrw_ovf", 32'(a_ovf), 32'd0);
      a_pop(8'h11);
      a_pop(8'h12);
      a_pop(8'h13);
      a_pop(8'h55);
      chk("a_fullrw_empty", 32'(a_empty), 32'd1);

      // Simultaneous write and read on an empty FIFO: read rejected.
      a_drive(1'b1, 8'h77, 1'b1);
      chk("a_emptyrw_level", 32'(a_level), 32'd1);
      chk("a_emptyrw_dout", 32'(a_dout), 32'h77);
      chk("a_emptyrw_unf", 32'(a_unf), 32'(ERR));
      a_pop(8'h77);
      a_drive(1'b0, 8'h00, 1'b0);
      chk("a_unf_sticky", 32'(a_unf), 32'(ERR));
      chk("a_unf_empty", 32'(a_empty), 32'd1);

      // Overflow: write alone while full.
      clr = 1'b1;
      a_drive(1'b0, 8'h00, 1'b0);
      clr = 1'b0;
      chk("a_clr_unf", 32'(a_unf), 32'd0);
      a_drive(1'b1, 8'h20, 1'b0);
      a_drive(1'b1, 8'h21, 1'b0);
      a_drive(1'b1, 8'h22, 1'b0);
      a_drive(1'b1, 8'h23, 1'b0);
      a_drive(1'b1, 8'h99, 1'b0);
      chk("a_ovf_level", 32'(a_level), 32'd4);
      chk("a_ovf_head", 32'(a_dout), 32'h20);
      chk("a_ovf_flag", 32'(a_ovf), 32'(ERR));
      a_pop(8'h20);
      a_pop(8'h21);
      a_pop(8'h22);
      a_pop(8'h23);
      chk("a_ovf_drained", 32'(a_empty), 32'd1);
      chk("a_ovf_sticky", 32'(a_ovf), 32'(ERR));

      // Clear mid-stream with a concurrent write.
      a_drive(1'b1, 8'h30, 1'b0);
      a_drive(1'b1, 8'h31, 1'b0);
      chk("a_pre_clr_level", 32'(a_level), 32'd2);
      clr = 1'b1;
      a_drive(1'b1, 8'h32, 1'b0);
      clr = 1'b0;
      chk("a_clr_level", 32'(a_level), 32'd0);
      chk("a_clr_empty", 32'(a_empty), 32'd1);
      chk("a_clr_valid", 32'(a_valid), 32'd0);
      chk("a_clr_dout", 32'(a_dout), 32'h0);
      chk("a_clr_ovf", 32'(a_ovf), 32'd0);
      chk("a_clr_unf2", 32'(a_unf), 32'd0);
      a_drive(1'b1, 8'h40, 1'b0);
      chk("a_post_clr_dout", 32'(a_dout), 32'h40);
      a_pop(8'h40);
      a_drive(1'b0, 8'h00, 1'b0);
      chk("a_queue_drained", 32'(a_q.size()), 32'd0);

      // Registered-output DEPTH=3: ten values through with wrapping pointers.
      b_drive(1'b1, 8'd1, 1'b0);
      chk("b_level1", 32'(b_level), 32'd1);
      chk("b_ae1", 32'(b_ae), 32'd1);
      chk("b_noread_valid", 32'(b_valid), 32'd0);
      b_drive(1'b1, 8'd2, 1'b0);
      chk("b_level2", 32'(b_level), 32'd2);
      chk("b_af2", 32'(b_af), 32'd1);
      b_drive(1'b1, 8'd3, 1'b0);
      chk("b_level3", 32'(b_level), 32'd3);
      chk("b_full3", 32'(b_full), 32'd1);
      for (int i = 4; i <= 10; i++) begin
         b_q.push_back(8'(i - 3));
         b_drive(1'b1, 8'(i), 1'b1);
         chk("b_pair_level", 32'(b_level), 32'd3);
      end
      for (int i = 8; i <= 10; i++) begin
         b_q.push_back(8'(i));
         b_drive(1'b0, 8'h00, 1'b1);
         chk("b_drain_level", 32'(b_level), 32'(10 - i));
      end
      b_drive(1'b0, 8'h00, 1'b0);
      chk("b_hold_valid", 32'(b_valid), 32'd0);
      chk("b_hold_dout", 32'(b_dout), 32'd10);
      chk("b_empty_end", 32'(b_empty), 32'd1);
      b_drive(1'b0, 8'h00, 1'b0);
      chk("b_queue_drained", 32'(b_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
